// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite write-path definitions: response codes, feedback codes, b_resp_ctrl states.
// Pure declarations; no latency or backpressure of its own.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Reserved on the completion feedback path: the AW block uses it to request a retry.
    localparam logic [1:0] FB_RETRY    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_RESP   = 2'd2,
        ST_ACK    = 2'd3
    } b_state_e;

endpackage

// File: rtl/b_resp_ctrl_if.sv
// Signals between b_resp_ctrl, the AW/W channel blocks, register memory and the B channel.
// slave = b_resp_ctrl side, master = surrounding write path.
interface b_resp_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                      ADDRREADY;
    logic                      DATAREADY;
    logic [ADDR_WIDTH-1:0]     AWADDRIN;
    logic [DATA_WIDTH-1:0]     WDATAIN;
    logic [DATA_WIDTH/8-1:0]   WSTRBIN;
    logic                      MEM_WE;
    logic [ADDR_WIDTH-3:0]     MEM_ADDR;
    logic [DATA_WIDTH-1:0]     MEM_WDATA;
    logic [DATA_WIDTH/8-1:0]   MEM_WSTRB;
    logic                      MEM_ERR;
    logic                      BVALID;
    logic                      BREADY;
    logic [1:0]                BRESP;
    logic                      BRESPREADY;
    logic [1:0]                BRESPOUT;

    modport slave (
        input  ADDRREADY, DATAREADY, AWADDRIN, WDATAIN, WSTRBIN, MEM_ERR, BREADY,
        output MEM_WE, MEM_ADDR, MEM_WDATA, MEM_WSTRB, BVALID, BRESP, BRESPREADY, BRESPOUT
    );

    modport master (
        output ADDRREADY, DATAREADY, AWADDRIN, WDATAIN, WSTRBIN, MEM_ERR, BREADY,
        input  MEM_WE, MEM_ADDR, MEM_WDATA, MEM_WSTRB, BVALID, BRESP, BRESPREADY, BRESPOUT
    );

endinterface

// File: rtl/wr_addr_decode.sv
// Byte address -> register index plus out-of-range flag; purely combinational, no backpressure.
// Shared with the read path, so it carries no write-specific state.
module wr_addr_decode #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-3:0] idx,
    output logic                  decerr
);
    // Byte lane within the word carries no meaning for a register access.
    logic unused_lsb;
    assign unused_lsb = ^addr[1:0];

    assign idx    = addr[ADDR_WIDTH-1:2];
    assign decerr = (int'(idx) >= NUM_REGS);

endmodule

// File: rtl/b_resp_ctrl.sv
// Write commit + B response: capture when AW and W both ready, commit with bounded retry, answer on B.
// Capture to completion pulse is 3 cycles minimum; each retry or BREADY stall cycle adds one.
module b_resp_ctrl
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int MAX_RETRY  = 2
) (
    input  logic          clk,
    input  logic          resetn,
    b_resp_ctrl_if.slave  bus
);
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    b_state_e            state, state_nxt;
    logic [CNT_W-1:0]    retry_cnt, retry_cnt_nxt;
    logic                decerr_q, decerr_nxt;
    logic [1:0]          bresp_q, bresp_nxt;
    logic [IDX_W-1:0]    addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic [STRB_W-1:0]   strb_q, strb_nxt;

    logic [IDX_W-1:0]    dec_idx;
    logic                dec_err;

    wr_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_decode (
        .addr   (bus.AWADDRIN),
        .idx    (dec_idx),
        .decerr (dec_err)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            retry_cnt <= '0;
            decerr_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_cnt_nxt;
            decerr_q  <= decerr_nxt;
            bresp_q   <= bresp_nxt;
            addr_q    <= addr_nxt;
            data_q    <= data_nxt;
            strb_q    <= strb_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        retry_cnt_nxt = retry_cnt;
        decerr_nxt    = decerr_q;
        bresp_nxt     = bresp_q;
        addr_nxt      = addr_q;
        data_nxt      = data_q;
        strb_nxt      = strb_q;
        case (state)
            ST_IDLE: begin
                if (bus.ADDRREADY && bus.DATAREADY) begin
                    addr_nxt      = dec_idx;
                    data_nxt      = bus.WDATAIN;
                    strb_nxt      = bus.WSTRBIN;
                    decerr_nxt    = dec_err;
                    retry_cnt_nxt = '0;
                    state_nxt     = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (decerr_q) begin
                    bresp_nxt = RESP_DECERR;
                    state_nxt = ST_RESP;
                end else if (!bus.MEM_ERR) begin
                    bresp_nxt = RESP_OKAY;
                    state_nxt = ST_RESP;
                end else if (int'(retry_cnt) < MAX_RETRY) begin
                    // Counter only advances below the limit, so it saturates instead of wrapping.
                    retry_cnt_nxt = retry_cnt + CNT_W'(1);
                end else begin
                    bresp_nxt = RESP_SLVERR;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.BREADY) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Every output is a decode of registered state, never of this cycle's inputs.
    assign bus.MEM_WE     = (state == ST_COMMIT) && !decerr_q;
    assign bus.MEM_ADDR   = addr_q;
    assign bus.MEM_WDATA  = data_q;
    assign bus.MEM_WSTRB  = strb_q;
    assign bus.BVALID     = (state == ST_RESP);
    assign bus.BRESP      = bresp_q;
    assign bus.BRESPREADY = (state == ST_ACK);
    assign bus.BRESPOUT   = (state == ST_ACK) ? bresp_q : RESP_OKAY;

endmodule

// File: tb/tb_b_resp_ctrl.sv
// Directed plus randomized transactions against a transaction-level model of the write response.
module tb_b_resp_ctrl;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NREGS = 4;
    localparam int MAXR  = 2;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    b_resp_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    b_resp_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NREGS),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_we"}, 32'(bus.MEM_WE), 0);
        chk({tag, "_bvalid"}, 32'(bus.BVALID), 0);
        chk({tag, "_bresprdy"}, 32'(bus.BRESPREADY), 0);
    endtask

    // One write transaction. err_k = number of leading attempts the memory rejects,
    // dly = BVALID cycles with BREADY low, stall = cycles with only ADDRREADY high,
    // hold = upstream keeps its ready flags up one extra cycle after capture.
    task automatic run_txn(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int err_k, input int dly, input int stall, input bit hold);
        int exp_idx, exp_att, exp_commit, exp_lat;
        logic [1:0] exp_resp;
        bit dec, done;
        int cyc, we_cnt, bv_cnt, first_we, first_bv, lat;

        exp_idx = int'(a) / 4;
        dec     = (exp_idx >= NREGS);
        if (dec) begin
            exp_att = 0; exp_resp = 2'b11; exp_commit = 1;
        end else if (err_k > MAXR) begin
            exp_att = MAXR + 1; exp_resp = 2'b10; exp_commit = exp_att;
        end else begin
            exp_att = err_k + 1; exp_resp = 2'b00; exp_commit = exp_att;
        end
        exp_lat = exp_commit + dly + 2;

        bus.AWADDRIN  = a;
        bus.WDATAIN   = d;
        bus.WSTRBIN   = s;
        bus.MEM_ERR   = 1'b0;
        bus.BREADY    = (dly == 0);
        bus.ADDRREADY = 1'b1;
        bus.DATAREADY = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk_quiet("stall");
        end
        bus.DATAREADY = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.ADDRREADY = 1'b0;
            bus.DATAREADY = 1'b0;
            bus.AWADDRIN  = ~a;
            bus.WDATAIN   = ~d;
        end

        cyc = 0; we_cnt = 0; bv_cnt = 0; first_we = 0; first_bv = 0; lat = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (hold && cyc == 2) begin
                bus.ADDRREADY = 1'b0;
                bus.DATAREADY = 1'b0;
            end
            if (bus.MEM_WE) begin
                we_cnt++;
                if (we_cnt == 1) begin
                    first_we = cyc;
                    chk("mem_addr", 32'(bus.MEM_ADDR), exp_idx);
                    chk("mem_wdata", bus.MEM_WDATA, d);
                    chk("mem_wstrb", 32'(bus.MEM_WSTRB), 32'(s));
                end
                bus.MEM_ERR = (we_cnt <= err_k);
            end else begin
                bus.MEM_ERR = 1'b0;
            end
            if (bus.BVALID) begin
                bv_cnt++;
                if (bv_cnt == 1) first_bv = cyc;
                chk("bresp", 32'(bus.BRESP), 32'(exp_resp));
                bus.BREADY = (bv_cnt > dly);
            end
            if (bus.BRESPREADY) begin
                done = 1'b1;
                lat  = cyc;
                chk("brespout", 32'(bus.BRESPOUT), 32'(exp_resp));
                bus.BREADY = 1'b0;
            end
        end
        chk("completed", 32'(done), 1);
        chk("latency", lat, exp_lat);
        chk("attempts", we_cnt, exp_att);
        chk("bvalid_start", first_bv, exp_commit + 1);
        chk("bvalid_len", bv_cnt, dly + 1);
        if (!dec) chk("we_start", first_we, 1);
        @(negedge clk);
        chk_quiet("after_ack");
    endtask

    initial begin
        int guard;
        checks = 0;
        errors = 0;
        resetn        = 1'b0;
        bus.ADDRREADY = 1'b0;
        bus.DATAREADY = 1'b0;
        bus.AWADDRIN  = '0;
        bus.WDATAIN   = '0;
        bus.WSTRBIN   = '0;
        bus.MEM_ERR   = 1'b0;
        bus.BREADY    = 1'b0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_bresp", 32'(bus.BRESP), 0);
        chk("reset_brespout", 32'(bus.BRESPOUT), 0);
        chk("reset_mem_addr", 32'(bus.MEM_ADDR), 0);
        chk("reset_mem_wdata", bus.MEM_WDATA, 0);
        chk("reset_mem_wstrb", 32'(bus.MEM_WSTRB), 0);
        resetn = 1'b1;
        @(negedge clk);

        run_txn(5'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0);
        run_txn(5'h1C, 32'h12345678, 4'hF, 0, 0, 0, 1'b0);
        run_txn(5'h04, 32'hA5A5A5A5, 4'h3, 2, 0, 0, 1'b0);
        run_txn(5'h0C, 32'h0BADF00D, 4'hC, 99, 0, 0, 1'b0);
        run_txn(5'h00, 32'hCAFEF00D, 4'h1, 0, 5, 0, 1'b0);
        run_txn(5'h05, 32'h00000001, 4'h0, 0, 1, 0, 1'b0);
        run_txn(5'h0B, 32'hFEEDFACE, 4'h5, 1, 0, 4, 1'b0);

        // Reset while the response is pending: no completion may follow.
        bus.AWADDRIN  = 5'h04;
        bus.WDATAIN   = 32'h55AA55AA;
        bus.WSTRBIN   = 4'hF;
        bus.BREADY    = 1'b0;
        bus.ADDRREADY = 1'b1;
        bus.DATAREADY = 1'b1;
        @(posedge clk);
        #1;
        bus.ADDRREADY = 1'b0;
        bus.DATAREADY = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.BVALID && guard < 10);
        chk("rst_reached_resp", 32'(bus.BVALID), 1);
        resetn = 1'b0;
        #1;
        chk_quiet("rst_async");
        chk("rst_bresp", 32'(bus.BRESP), 0);
        chk("rst_mem_addr", 32'(bus.MEM_ADDR), 0);
        chk("rst_mem_wdata", bus.MEM_WDATA, 0);
        bus.BREADY = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet("rst_idle");
        end
        bus.BREADY = 1'b0;
        run_txn(5'h0C, 32'h13579BDF, 4'hA, 0, 0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [4:0]  ra;
            logic [31:0] rd;
            logic [3:0]  rs;
            ra = 5'($urandom_range(0, 31));
            rd = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            run_txn(ra, rd, rs, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
